// File: rtl/product_frame_accumulator_if.sv
// -----------------------------------------------------------------------------
// product_frame_accumulator_if
// Handshake bundle for the frame accumulator: the product input stream
// (i_valid / i_ready / i_data0) and the frame-result output stream
// (o_valid / o_ready / o_data0 / o_overflow).
//   master : environment side (drives products and o_ready)
//   slave  : accumulator side (drives i_ready and the result)
// Parameter ACC_W sets the result width and must match the accumulator.
// -----------------------------------------------------------------------------
interface product_frame_accumulator_if #(
  parameter int ACC_W = 40
) ();
  logic             i_valid;
  logic             i_ready;
  logic [31:0]      i_data0;
  logic             o_valid;
  logic             o_ready;
  logic [ACC_W-1:0] o_data0;
  logic             o_overflow;

  modport master (
    output i_valid, i_data0, o_ready,
    input  i_ready, o_valid, o_data0, o_overflow
  );

  modport slave (
    input  i_valid, i_data0, o_ready,
    output i_ready, o_valid, o_data0, o_overflow
  );
endinterface

// File: rtl/product_frame_accumulator.sv
// -----------------------------------------------------------------------------
// product_frame_accumulator
// Sums FRAME_LEN consecutive 32-bit unsigned products (from the x14628
// multiplier stage) into an ACC_W-bit result and presents it on a valid/ready
// output, holding it stable until accepted. Back-pressure reaches upstream
// through i_ready, which is combinational in o_ready.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : product_frame_accumulator_if.slave
//           i_valid/i_ready/i_data0 : product input stream
//           o_valid/o_ready/o_data0 : frame result stream
//           o_overflow              : frame sum exceeded 2^ACC_W-1
//
// Parameters: FRAME_LEN (1..65535), ACC_W (32..64).
// Build option: define ACC_SAT_EN to make the accumulator saturate at
// all-ones on overflow instead of wrapping modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module product_frame_accumulator #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 40
) (
  input  logic                              clk,
  input  logic                              rst_n,
  product_frame_accumulator_if.slave        bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [15:0]      LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [15:0]      cnt_r, cnt_nxt_s;
  logic             sticky_r, sticky_nxt_s;
  logic             o_valid_r, o_valid_nxt_s;
  logic [ACC_W-1:0] o_data_r, o_data_nxt_s;
  logic             o_ovf_r, o_ovf_nxt_s;

  logic             i_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             last_s;
  logic [ACC_W:0]   sum_s;
  logic             carry_s;
  logic [ACC_W-1:0] step_s;

  // Handshake qualifiers; HOLD only accepts a product when the result leaves.
  always_comb begin
    i_ready_s  = (state_r == ACCUM) | bus.o_ready;
    in_xfer_s  = bus.i_valid & i_ready_s;
    out_xfer_s = o_valid_r & bus.o_ready;
    last_s     = (cnt_r == LAST_IDX);
  end

  // One-bit-wider add so the carry out is the overflow indication.
  always_comb begin
    sum_s   = {1'b0, acc_r} + {{(ACC_W + 1 - 32){1'b0}}, bus.i_data0};
    carry_s = sum_s[ACC_W];
`ifdef ACC_SAT_EN
    // Once clamped, acc stays all-ones: any further non-zero add carries again.
    if (carry_s) begin
      step_s = ACC_MAX;
    end else begin
      step_s = sum_s[ACC_W-1:0];
    end
`else
    step_s = sum_s[ACC_W-1:0];
`endif
  end

  // Next-state logic: a frame-closing product keeps/enters HOLD, an accepted
  // result without a new one returns to ACCUM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (in_xfer_s && last_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      HOLD: begin
        if (out_xfer_s && !(in_xfer_s && last_s)) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = ACCUM;
      end
    endcase
  end

  // Datapath: acc/cnt/sticky are already cleared when a frame closes, so a
  // product accepted in HOLD naturally starts the next frame (or, with
  // FRAME_LEN==1, becomes the next result) through the same step.
  always_comb begin
    acc_nxt_s     = acc_r;
    cnt_nxt_s     = cnt_r;
    sticky_nxt_s  = sticky_r;
    o_valid_nxt_s = o_valid_r;
    o_data_nxt_s  = o_data_r;
    o_ovf_nxt_s   = o_ovf_r;
    if (in_xfer_s) begin
      if (last_s) begin
        acc_nxt_s     = {ACC_W{1'b0}};
        cnt_nxt_s     = 16'd0;
        sticky_nxt_s  = 1'b0;
        o_data_nxt_s  = step_s;
        o_ovf_nxt_s   = sticky_r | carry_s;
        o_valid_nxt_s = 1'b1;
      end else begin
        acc_nxt_s     = step_s;
        cnt_nxt_s     = cnt_r + 16'd1;
        sticky_nxt_s  = sticky_r | carry_s;
        o_valid_nxt_s = o_valid_r & ~out_xfer_s;
      end
    end else if (out_xfer_s) begin
      o_valid_nxt_s = 1'b0;
    end else begin
      o_valid_nxt_s = o_valid_r;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ACCUM;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= 16'd0;
      sticky_r  <= 1'b0;
      o_valid_r <= 1'b0;
      o_data_r  <= {ACC_W{1'b0}};
      o_ovf_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      cnt_r     <= cnt_nxt_s;
      sticky_r  <= sticky_nxt_s;
      o_valid_r <= o_valid_nxt_s;
      o_data_r  <= o_data_nxt_s;
      o_ovf_r   <= o_ovf_nxt_s;
    end
  end

  assign bus.i_ready    = i_ready_s;
  assign bus.o_valid    = o_valid_r;
  assign bus.o_data0    = o_data_r;
  assign bus.o_overflow = o_ovf_r;

endmodule
